// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: parity modes,
// FSM state encoding and the 3-sample majority vote.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_DONE
    } rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Oversample tick counter and 3-sample majority vote around mid-bit.
// Produces the voted bit plus mid-bit and end-of-bit strobes.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sample_tick,
    input  logic i_rx_d,
    input  logic i_run,
    input  logic i_start,
    output logic o_bit_val,
    output logic o_mid_stb,
    output logic o_end_stb
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int M      = OVERSAMPLE / 2;

    localparam logic [TICK_W-1:0] C_S0   = TICK_W'(M - 1);
    localparam logic [TICK_W-1:0] C_S1   = TICK_W'(M);
    localparam logic [TICK_W-1:0] C_S2   = TICK_W'(M + 1);
    localparam logic [TICK_W-1:0] C_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] C_ONE  = TICK_W'(1);

    logic [TICK_W-1:0] r_tick_cnt;
    logic              r_s0;
    logic              r_s1;

    // The detecting tick counts as tick 0 of the start bit, so a start loads 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (i_start) begin
            r_tick_cnt <= C_ONE;
        end else if (!i_run) begin
            r_tick_cnt <= '0;
        end else if (i_sample_tick) begin
            r_tick_cnt <= (r_tick_cnt == C_LAST) ? '0 : r_tick_cnt + C_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (i_sample_tick && (r_tick_cnt == C_S0)) begin
            r_s0 <= i_rx_d;
        end
        if (i_sample_tick && (r_tick_cnt == C_S1)) begin
            r_s1 <= i_rx_d;
        end
    end

    assign o_bit_val = maj3(r_s0, r_s1, i_rx_d);
    assign o_mid_stb = i_run & i_sample_tick & (r_tick_cnt == C_S2);
    assign o_end_stb = i_run & i_sample_tick & (r_tick_cnt == C_LAST);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with valid/ready holding register and overrun pulse.
// Define UART_RX_SYNC_EN to insert a 2-flop input synchroniser on i_rx_d.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_sample_tick,
    input  logic                 i_rx_d,
    input  logic                 i_rx_ready,
    output logic [DATA_BITS-1:0] o_rx_d,
    output logic                 o_rx_valid,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_overrun
);

    localparam int BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [BIT_W-1:0] C_LAST_DATA = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] C_LAST_STOP = BIT_W'(STOP_BITS - 1);
    localparam logic [BIT_W-1:0] C_BIT_ONE   = BIT_W'(1);
    localparam logic             C_ODD       = (PARITY_MODE == PARITY_ODD);
    localparam logic             C_HAS_PAR   = (PARITY_MODE != PARITY_NONE);

    logic w_rx;

`ifdef UART_RX_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_rx_d;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx = r_sync2;
`else
    assign w_rx = i_rx_d;
`endif

    rx_state_t             r_state;
    rx_state_t             w_next;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_perr;
    logic                  r_ferr;
    logic                  w_bit_val;
    logic                  w_mid;
    logic                  w_end;
    logic                  w_start;
    logic                  w_run;
    logic                  w_load;
    logic [DATA_BITS-1:0]  r_rx_d;
    logic                  r_rx_valid;
    logic                  r_parity_err;
    logic                  r_frame_err;
    logic                  r_overrun;

    assign w_start = (r_state == ST_IDLE) & i_sample_tick & ~w_rx;
    assign w_run   = (r_state != ST_IDLE) & (r_state != ST_DONE);
    assign w_load  = (r_state == ST_DONE) & (~r_rx_valid | i_rx_ready);

    uart_rx_sampler #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_sampler (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_sample_tick (i_sample_tick),
        .i_rx_d        (w_rx),
        .i_run         (w_run),
        .i_start       (w_start),
        .o_bit_val     (w_bit_val),
        .o_mid_stb     (w_mid),
        .o_end_stb     (w_end)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // The last stop bit ends at its mid sample so a following start edge is not missed.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_next = ST_START;
                end
            end
            ST_START: begin
                if (w_mid && w_bit_val) begin
                    w_next = ST_IDLE;
                end else if (w_end) begin
                    w_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_end && (r_bit_cnt == C_LAST_DATA)) begin
                    w_next = C_HAS_PAR ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (w_end) begin
                    w_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_mid && (r_bit_cnt == C_LAST_STOP)) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bit_cnt <= '0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            case (r_state)
                ST_START: begin
                    r_bit_cnt <= '0;
                    r_perr    <= 1'b0;
                    r_ferr    <= 1'b0;
                end
                ST_DATA: begin
                    if (w_end) begin
                        r_bit_cnt <= (r_bit_cnt == C_LAST_DATA) ? '0 : r_bit_cnt + C_BIT_ONE;
                    end
                end
                ST_PARITY: begin
                    if (w_mid) begin
                        r_perr <= w_bit_val ^ (^r_shift) ^ C_ODD;
                    end
                end
                ST_STOP: begin
                    if (w_mid && !w_bit_val) begin
                        r_ferr <= 1'b1;
                    end
                    if (w_end) begin
                        r_bit_cnt <= r_bit_cnt + C_BIT_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // LSB arrives first: after DATA_BITS shifts the first bit sits at bit 0.
    always_ff @(posedge clk) begin
        if ((r_state == ST_DATA) && w_mid) begin
            r_shift <= {w_bit_val, r_shift[DATA_BITS-1:1]};
        end
    end

    // A load in DONE takes priority over a same-cycle consume.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_d       <= '0;
            r_rx_valid   <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= (r_state == ST_DONE) & ~w_load;
            if (w_load) begin
                r_rx_d       <= r_shift;
                r_parity_err <= r_perr;
                r_frame_err  <= r_ferr;
                r_rx_valid   <= 1'b1;
            end else if (i_rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign o_rx_d       = r_rx_d;
    assign o_rx_valid   = r_rx_valid;
    assign o_parity_err = r_parity_err;
    assign o_frame_err  = r_frame_err;
    assign o_overrun    = r_overrun;

endmodule
